// File: rtl/seven_seg_display_ctrl.sv
// seven_seg_display_ctrl: latches a hex value or a binary value converted to BCD and drives
// N active-low seven-segment digits with leading-zero blanking, overflow dashes and blink.
module seven_seg_display_ctrl #(
  parameter int N_DIGITS  = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic [4*N_DIGITS-1:0]   i_value,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_mode_dec,
  input  logic                    i_blank_lz,
  input  logic                    i_blink_en,
  output logic [7*N_DIGITS-1:0]   o_display,
  output logic                    o_overflow
);
  localparam int W  = 4*N_DIGITS;
  localparam int CW = $clog2(W+1);
  localparam int BW = $clog2(BLINK_DIV);
  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p*10;
    return p;
  endfunction
  localparam longint unsigned DEC_LIM = pow10(N_DIGITS) - 1;
  localparam logic [W-1:0] DEC_MAX = W'(DEC_LIM);
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic {IDLE, CONV} state_t;
  state_t state_q, state_d;
  logic [W-1:0] sr_q, sr_d, bcd_q, bcd_d, bcd_adj, bcd_nxt, digits_q, digits_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [7*N_DIGITS-1:0] disp_q, disp_d, segs;
  logic blank_q, blank_d, blank_pend_q, blank_pend_d;
  logic ovf_q, ovf_d, dash_q, dash_d, shown_q, shown_d, phase_q, phase_d;
  logic acc, too_big, dec_ok, dec_ovf, hex_ld, conv, last, lead;
  assign acc     = i_valid & o_ready;
  assign too_big = i_value > DEC_MAX;
  assign dec_ok  = acc & i_mode_dec & ~too_big;
  assign dec_ovf = acc & i_mode_dec & too_big;
  assign hex_ld  = acc & ~i_mode_dec;
  assign conv    = state_q == CONV;
  assign last    = conv && cnt_q == CW'(W-1);
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (dec_ok ? CONV : IDLE) : (last ? IDLE : CONV);
  end
  always_comb begin
    o_ready = state_q == IDLE;
  end
  // Shift-add-3: correct every BCD digit >= 5 before shifting in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < N_DIGITS; k++)
      bcd_adj[4*k+:4] = (bcd_q[4*k+:4] >= 4'd5) ? bcd_q[4*k+:4] + 4'd3 : bcd_q[4*k+:4];
    bcd_nxt = {bcd_adj[W-2:0], sr_q[W-1]};
  end
  always_comb begin
    sr_d         = dec_ok ? i_value : (conv ? {sr_q[W-2:0], 1'b0} : sr_q);
    bcd_d        = dec_ok ? '0 : (conv ? bcd_nxt : bcd_q);
    cnt_d        = dec_ok ? '0 : (conv ? cnt_q + 1'b1 : cnt_q);
    digits_d     = hex_ld ? i_value : (last ? bcd_nxt : digits_q);
    blank_pend_d = dec_ok ? i_blank_lz : blank_pend_q;
    blank_d      = (hex_ld | dec_ovf) ? i_blank_lz : (last ? blank_pend_q : blank_q);
    ovf_d        = acc ? dec_ovf : ovf_q;
    dash_d       = dec_ovf ? 1'b1 : ((hex_ld | last) ? 1'b0 : dash_q);
    shown_d      = shown_q | hex_ld | dec_ovf | last;
    bc_d         = (bc_q == BW'(BLINK_DIV-1)) ? '0 : bc_q + 1'b1;
    phase_d      = phase_q ^ (bc_q == BW'(BLINK_DIV-1));
  end
  // Dashes bypass blanking; the old value stays on screen until a new one is latched.
  always_comb begin
    lead = 1'b1;
    segs = '1;
    for (int k = N_DIGITS-1; k >= 0; k--) begin
      lead = lead & (digits_q[4*k+:4] == 4'd0);
      segs[7*k+:7] = dash_q ? DASH : ((blank_q && lead && k != 0) ? 7'h7f : GLYPH[digits_q[4*k+:4]]);
    end
    disp_d = (!shown_q || (i_blink_en && phase_q)) ? '1 : segs;
  end
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sr_q         <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      digits_q     <= '0;
      blank_pend_q <= 1'b0;
      blank_q      <= 1'b0;
      ovf_q        <= 1'b0;
      dash_q       <= 1'b0;
      shown_q      <= 1'b0;
      bc_q         <= '0;
      phase_q      <= 1'b0;
      disp_q       <= '1;
    end else begin
      sr_q         <= sr_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      blank_pend_q <= blank_pend_d;
      blank_q      <= blank_d;
      ovf_q        <= ovf_d;
      dash_q       <= dash_d;
      shown_q      <= shown_d;
      bc_q         <= bc_d;
      phase_q      <= phase_d;
      disp_q       <= disp_d;
    end
  end
  assign o_display  = disp_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// tb_seven_seg_display_ctrl: directed vectors with hand-computed segment patterns.
module tb_seven_seg_display_ctrl;
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, GA = 7'b0001000;
  localparam logic [6:0] GF = 7'b0001110, BL = 7'b1111111, DS = 7'b0111111;
  logic clk, rst_n, valid, ready, mode_dec, blank_lz, blink_en, ovf;
  logic [23:0] value;
  logic [41:0] disp, old_disp;
  int e;
  int n_vec = 0;
  int n_err = 0;
  seven_seg_display_ctrl #(.N_DIGITS(6), .BLINK_DIV(4)) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_value(value), .i_valid(valid), .o_ready(ready),
    .i_mode_dec(mode_dec), .i_blank_lz(blank_lz), .i_blink_en(blink_en),
    .o_display(disp), .o_overflow(ovf)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e <= 0;
    else e <= e + 1;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [41:0] d6(input logic [6:0] a5, a4, a3, a2, a1, a0);
    return {a5, a4, a3, a2, a1, a0};
  endfunction
  initial begin
    rst_n = 1'b0; valid = 1'b0; mode_dec = 1'b0; blank_lz = 1'b0; blink_en = 1'b0; value = '0;
    repeat (3) step();
    chk("rst_hold_disp", disp, {42{1'b1}});
    chk("rst_hold_ready", ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_disp", disp, {42{1'b1}});
    chk("rst_ready", ready, 1'b1);
    chk("rst_ovf", ovf, 1'b0);
    // hex with leading-zero blanking
    valid = 1'b1; mode_dec = 1'b0; blank_lz = 1'b1; value = 24'h00A3F1;
    step();
    valid = 1'b0;
    chk("hex_lat_disp", disp, {42{1'b1}});
    chk("hex_ready", ready, 1'b1);
    step();
    chk("hex_disp", disp, d6(BL, BL, GA, G3, GF, G1));
    chk("hex_ovf", ovf, 1'b0);
    // decimal conversion
    old_disp = d6(BL, BL, GA, G3, GF, G1);
    valid = 1'b1; mode_dec = 1'b1; blank_lz = 1'b0; value = 24'd123456;
    step();
    valid = 1'b0;
    chk("dec_ready_c1", ready, 1'b0);
    for (int i = 2; i <= 24; i++) begin
      step();
      chk($sformatf("dec_ready_c%0d", i), ready, 1'b0);
    end
    chk("dec_hold_disp", disp, old_disp);
    step();
    chk("dec_ready_back", ready, 1'b1);
    chk("dec_disp_c25_pre", disp, old_disp);
    step();
    chk("dec_disp", disp, d6(G1, G2, G3, G4, G5, G6));
    chk("dec_ovf", ovf, 1'b0);
    // decimal overflow
    valid = 1'b1; mode_dec = 1'b1; blank_lz = 1'b1; value = 24'd1000000;
    step();
    valid = 1'b0;
    chk("ovf_ready", ready, 1'b1);
    step();
    chk("ovf_flag", ovf, 1'b1);
    chk("ovf_disp", disp, d6(DS, DS, DS, DS, DS, DS));
    chk("ovf_ready2", ready, 1'b1);
    // hex zero, blanked down to a single "0"; clears overflow
    valid = 1'b1; mode_dec = 1'b0; blank_lz = 1'b1; value = 24'h000000;
    step();
    valid = 1'b0;
    chk("zero_ovf_clr", ovf, 1'b0);
    step();
    chk("zero_disp", disp, d6(BL, BL, BL, BL, BL, G0));
    // blink: display after edge e reflects the phase held before that edge
    blink_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("blink_%0d", i), disp,
          (((e-1)/4) % 2 == 1) ? {42{1'b1}} : d6(BL, BL, BL, BL, BL, G0));
    end
    blink_en = 1'b0;
    step();
    chk("blink_off", disp, d6(BL, BL, BL, BL, BL, G0));
    // reset in the middle of a conversion
    valid = 1'b1; mode_dec = 1'b1; blank_lz = 1'b0; value = 24'd999999;
    step();
    valid = 1'b0;
    repeat (10) step();
    chk("mid_ready", ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_disp", disp, {42{1'b1}});
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b1; mode_dec = 1'b0; blank_lz = 1'b0; value = 24'h000005;
    step();
    valid = 1'b0;
    chk("post_rst_ready", ready, 1'b1);
    step();
    chk("post_rst_disp", disp, d6(G0, G0, G0, G0, G0, G5));
    repeat (30) step();
    chk("post_rst_stable", disp, d6(G0, G0, G0, G0, G0, G5));
    chk("post_rst_ready2", ready, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
